// File: rtl/deserializer_stream.sv
// Serial-to-parallel converter with selectable bit order, early frame end and a
// one-entry valid/ready output holding register that drops (and flags) words it cannot accept.
module deserializer_stream #(
  parameter int  DATA_BUS_WIDTH = 16,
  parameter bit  LSB_FIRST      = 1'b0,
  localparam int LEN_W          = $clog2(DATA_BUS_WIDTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic                      data_i,
  input  logic                      data_val_i,
  input  logic                      data_last_i,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [LEN_W-1:0]          deser_len_o,
  output logic                      deser_data_val_o,
  input  logic                      deser_data_rdy_i,
  output logic                      deser_ovf_o
);

  localparam int CNT_W = $clog2(DATA_BUS_WIDTH);

  logic [CNT_W-1:0]          cnt_q;
  logic [DATA_BUS_WIDTH-1:0] asm_q;
  logic [DATA_BUS_WIDTH-1:0] word_c;
  logic [CNT_W-1:0]          pos_c;
  logic [LEN_W-1:0]          len_c;
  logic                      comp_c;
  logic                      free_c;

  // Current bit merged into the partial word; becomes the full word on completion.
  always_comb begin
    pos_c         = LSB_FIRST ? cnt_q : (CNT_W'(DATA_BUS_WIDTH - 1) - cnt_q);
    word_c        = asm_q;
    word_c[pos_c] = data_i;
    len_c         = LEN_W'(cnt_q) + LEN_W'(1);
    comp_c        = data_val_i && ((cnt_q == CNT_W'(DATA_BUS_WIDTH - 1)) || data_last_i);
    free_c        = !deser_data_val_o || deser_data_rdy_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (data_val_i) begin
      if (comp_c) begin
        cnt_q <= '0;
        asm_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
        asm_q <= word_c;
      end
    end
  end

  // Holding register: a new word may replace one that is handed off this same cycle.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      deser_data_o     <= '0;
      deser_len_o      <= '0;
      deser_data_val_o <= 1'b0;
      deser_ovf_o      <= 1'b0;
    end else begin
      deser_ovf_o <= comp_c && !free_c;
      if (comp_c && free_c) begin
        deser_data_o     <= word_c;
        deser_len_o      <= len_c;
        deser_data_val_o <= 1'b1;
      end else if (deser_data_val_o && deser_data_rdy_i) begin
        deser_data_val_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deserializer_stream.sv
// Bench: MSB-first and LSB-first instances share one stimulus stream and are
// checked against a frame-level reference model (bit queue + output-stage state).
module tb_deserializer_stream;
  localparam int W  = 8;
  localparam int LW = 4;

  logic clk = 1'b0, arst_n = 1'b1;
  logic d = 1'b0, v = 1'b0, l = 1'b0, r = 1'b0;
  logic [W-1:0]  q0, q1;
  logic [LW-1:0] n0, n1;
  logic val0, val1, ovf0, ovf1;

  always #5 clk = ~clk;

  deserializer_stream #(.DATA_BUS_WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk_i(clk), .arst_n_i(arst_n), .data_i(d), .data_val_i(v), .data_last_i(l),
    .deser_data_o(q0), .deser_len_o(n0), .deser_data_val_o(val0),
    .deser_data_rdy_i(r), .deser_ovf_o(ovf0));

  deserializer_stream #(.DATA_BUS_WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk_i(clk), .arst_n_i(arst_n), .data_i(d), .data_val_i(v), .data_last_i(l),
    .deser_data_o(q1), .deser_len_o(n1), .deser_data_val_o(val1),
    .deser_data_rdy_i(r), .deser_ovf_o(ovf1));

  int checks = 0, errors = 0;

  bit            bits[$];
  logic [W-1:0]  m0, m1;
  logic [LW-1:0] mlen;
  logic          mval, movf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    m0 = '0; m1 = '0; mlen = '0; mval = 1'b0; movf = 1'b0;
  endtask

  // One clock edge of the reference, using the inputs that were applied before it.
  task automatic model_edge();
    bit comp = 1'b0;
    logic [W-1:0] w0 = '0, w1 = '0;
    int n = 0;
    if (v) begin
      bits.push_back(d);
      if (bits.size() == W || l) comp = 1'b1;
    end
    if (comp) begin
      n = bits.size();
      for (int k = 0; k < n; k++) begin
        w0[W-1-k] = bits[k];
        w1[k]     = bits[k];
      end
      bits.delete();
    end
    movf = comp && mval && !r;
    if (comp && (!mval || r)) begin
      m0 = w0; m1 = w1; mlen = LW'(n); mval = 1'b1;
    end else if (mval && r) begin
      mval = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_val_msb"}, 32'(val0), 32'(mval));
    chk({tag, "_val_lsb"}, 32'(val1), 32'(mval));
    chk({tag, "_ovf_msb"}, 32'(ovf0), 32'(movf));
    chk({tag, "_ovf_lsb"}, 32'(ovf1), 32'(movf));
    if (mval) begin
      chk({tag, "_data_msb"}, 32'(q0), 32'(m0));
      chk({tag, "_data_lsb"}, 32'(q1), 32'(m1));
      chk({tag, "_len_msb"},  32'(n0), 32'(mlen));
      chk({tag, "_len_lsb"},  32'(n1), 32'(mlen));
    end
  endtask

  task automatic step(input string tag, input logic bd, input logic bv, input logic bl, input logic br);
    d = bd; v = bv; l = bl; r = br;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Sends the first n bits of b, MSB of b first on the wire.
  task automatic send_bits(input string tag, input logic [7:0] b, input int n,
                           input bit last, input logic rr);
    for (int i = 0; i < n; i++) step(tag, b[7-i], 1'b1, last && (i == n - 1), rr);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data_msb"}, 32'(q0), 32'h0);
    chk({tag, "_data_lsb"}, 32'(q1), 32'h0);
    chk({tag, "_len"},      32'(n0), 32'h0);
    chk({tag, "_val"},      32'(val0 | val1), 32'h0);
    chk({tag, "_ovf"},      32'(ovf0 | ovf1), 32'h0);
  endtask

  initial begin
    int sent;
    model_reset();
    #2 arst_n = 1'b0;
    #1 chk_zero("reset");
    @(posedge clk); #1;
    chk_zero("reset_hold");
    arst_n = 1'b1;

    // Full word 1,0,1,1,0,0,1,0 with consumer ready
    send_bits("t1", 8'hB2, 8, 1'b0, 1'b1);
    chk("t1_data_msb", 32'(q0), 32'hB2);
    chk("t1_data_lsb", 32'(q1), 32'h4D);
    chk("t1_len", 32'(n0), 32'd8);
    step("t1_idle", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_val_drop", 32'(val0), 32'h0);

    // Short frame 1,1,0 then a full frame must start at bit 0
    send_bits("t3", 8'hC0, 3, 1'b1, 1'b1);
    chk("t3_data_msb", 32'(q0), 32'hC0);
    chk("t3_data_lsb", 32'(q1), 32'h03);
    chk("t3_len", 32'(n0), 32'd3);
    send_bits("t3_next", 8'hB2, 8, 1'b0, 1'b1);
    chk("t3_next_data", 32'(q0), 32'hB2);
    step("t3_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Stalled consumer: second word is dropped with an overflow pulse
    send_bits("t4a", 8'hB2, 8, 1'b0, 1'b0);
    send_bits("t4b", 8'hFF, 8, 1'b0, 1'b0);
    chk("t4_ovf", 32'(ovf0), 32'h1);
    chk("t4_hold", 32'(q0), 32'hB2);
    step("t4_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_ovf_end", 32'(ovf0), 32'h0);
    step("t4_xfer", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_val_low", 32'(val0), 32'h0);
    step("t4_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Handshake coincides with completion of the next word
    send_bits("t5a", 8'hB2, 8, 1'b0, 1'b0);
    send_bits("t5b", 8'h0F, 7, 1'b0, 1'b0);
    step("t5b_last", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5_data", 32'(q0), 32'h0F);
    chk("t5_val", 32'(val0), 32'h1);
    chk("t5_ovf", 32'(ovf0), 32'h0);
    step("t5_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Partial frame with gaps, then async reset mid-cycle
    sent = 0;
    for (int c = 0; c < 40 && sent < 5; c++) begin
      logic gv;
      gv = 1'($urandom_range(0, 1));
      step("t6_part", 1'($urandom_range(0, 1)), gv, 1'b0, 1'b1);
      if (gv) sent++;
    end
    #2 arst_n = 1'b0;
    #1 chk_zero("t6_arst");
    model_reset();
    #1 arst_n = 1'b1;
    send_bits("t6_5a", 8'h5A, 8, 1'b0, 1'b1);
    chk("t6_data", 32'(q0), 32'h5A);
    chk("t6_len", 32'(n0), 32'd8);

    // Randomized traffic against the reference
    for (int c = 0; c < 600; c++)
      step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
